// File: rtl/matmul_pkg.sv
// Shared types and constants for the sequential matrix multiplier.
// Memory word 0 of every matrix is a header: [7:0]=rows, [15:8]=cols.
package matmul_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 7;
  localparam int HDR_ADDR  = 0;
  localparam int ELEM_BASE = 1;

  localparam int DIM_W     = 8;
  localparam int ROWS_LSB  = 0;
  localparam int COLS_LSB  = 8;
  localparam int MAX_ELEMS = 127;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDHDR,
    S_CHECK,
    S_HDR,
    S_MAC,
    S_WRITE,
    S_ERR,
    S_DONE
  } state_e;

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate unit with synchronous clear and enable.
// MATMUL_SAT_EN: accumulate in 2*DATA_W bits and saturate the output.
module matmul_mac
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] acc_o
);

`ifdef MATMUL_SAT_EN
  localparam logic signed [2*DATA_W-1:0] SAT_MAX =
    {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0] SAT_MIN =
    {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [2*DATA_W-1:0] acc_q, acc_d, prod;

  assign prod = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));

  always_comb begin
    acc_o = acc_q[DATA_W-1:0];
    if (acc_q > SAT_MAX) begin
      acc_o = SAT_MAX[DATA_W-1:0];
    end else if (acc_q < SAT_MIN) begin
      acc_o = SAT_MIN[DATA_W-1:0];
    end
  end
`else
  // Low half of a two's-complement product is sign-agnostic, so wrap is exact.
  logic [DATA_W-1:0] acc_q, acc_d, prod;

  assign prod  = a * b;
  assign acc_o = acc_q;
`endif

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matmul_fsm.sv
// Sequential C = A x B controller: reads headers, validates dimensions,
// one MAC per clock. Optional saturation via MATMUL_SAT_EN (in matmul_mac).
module matmul_fsm
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic [ADDR_W-1:0] Addr1,
  output logic [ADDR_W-1:0] Addr2,
  output logic [ADDR_W-1:0] Addr3,
  output logic [DATA_W-1:0] result,
  output logic              WE,
  output logic              Done,
  output logic              invalidmm,
  output state_e            dbg_state
);

  state_e state_q, state_d;
  logic [DIM_W-1:0] m_dim_q, m_dim_d, k_dim_q, k_dim_d;
  logic [DIM_W-1:0] k2_dim_q, k2_dim_d, n_dim_q, n_dim_d;
  logic [DIM_W-1:0] row_q, row_d, col_q, col_d, step_q, step_d;
  logic             inv_q, inv_d;

  logic              mac_en, mac_clr;
  logic [DATA_W-1:0] acc;

  logic [2*DIM_W-1:0] mn_size, mk_size, kn_size;
  logic               dims_bad;
  logic [ADDR_W-1:0]  a_idx, b_idx, c_idx;

  assign mn_size = (2*DIM_W)'(m_dim_q) * (2*DIM_W)'(n_dim_q);
  assign mk_size = (2*DIM_W)'(m_dim_q) * (2*DIM_W)'(k_dim_q);
  assign kn_size = (2*DIM_W)'(k2_dim_q) * (2*DIM_W)'(n_dim_q);

  assign dims_bad = (k_dim_q != k2_dim_q) ||
                    (m_dim_q == '0) || (k_dim_q == '0) ||
                    (k2_dim_q == '0) || (n_dim_q == '0) ||
                    (mn_size > (2*DIM_W)'(MAX_ELEMS)) ||
                    (mk_size > (2*DIM_W)'(MAX_ELEMS)) ||
                    (kn_size > (2*DIM_W)'(MAX_ELEMS));

  // Valid runs keep every product below 128, so ADDR_W-bit arithmetic is exact.
  assign a_idx = ADDR_W'(ELEM_BASE) + ADDR_W'(row_q) * ADDR_W'(k_dim_q) + ADDR_W'(step_q);
  assign b_idx = ADDR_W'(ELEM_BASE) + ADDR_W'(step_q) * ADDR_W'(n_dim_q) + ADDR_W'(col_q);
  assign c_idx = ADDR_W'(ELEM_BASE) + ADDR_W'(row_q) * ADDR_W'(n_dim_q) + ADDR_W'(col_q);

  always_comb begin
    state_d  = state_q;
    m_dim_d  = m_dim_q;
    k_dim_d  = k_dim_q;
    k2_dim_d = k2_dim_q;
    n_dim_d  = n_dim_q;
    row_d    = row_q;
    col_d    = col_q;
    step_d   = step_q;
    inv_d    = inv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RDHDR;
          inv_d   = 1'b0;
        end
      end
      S_RDHDR: begin
        m_dim_d  = data1[ROWS_LSB +: DIM_W];
        k_dim_d  = data1[COLS_LSB +: DIM_W];
        k2_dim_d = data2[ROWS_LSB +: DIM_W];
        n_dim_d  = data2[COLS_LSB +: DIM_W];
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        row_d   = '0;
        col_d   = '0;
        step_d  = '0;
        state_d = dims_bad ? S_ERR : S_HDR;
      end
      S_HDR: state_d = S_MAC;
      S_MAC: begin
        if (step_q == k_dim_q - DIM_W'(1)) begin
          step_d  = '0;
          state_d = S_WRITE;
        end else begin
          step_d = step_q + DIM_W'(1);
        end
      end
      S_WRITE: begin
        state_d = S_MAC;
        if (col_q == n_dim_q - DIM_W'(1)) begin
          col_d = '0;
          if (row_q == m_dim_q - DIM_W'(1)) begin
            state_d = S_DONE;
          end else begin
            row_d = row_q + DIM_W'(1);
          end
        end else begin
          col_d = col_q + DIM_W'(1);
        end
      end
      S_ERR: begin
        inv_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory-side outputs are decoded from the state so a reset clears them at once.
  always_comb begin
    Addr1   = ADDR_W'(HDR_ADDR);
    Addr2   = ADDR_W'(HDR_ADDR);
    Addr3   = ADDR_W'(HDR_ADDR);
    result  = '0;
    WE      = 1'b0;
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    case (state_q)
      S_RDHDR: mac_clr = 1'b1;
      S_HDR: begin
        WE = 1'b1;
        result[ROWS_LSB +: DIM_W] = m_dim_q;
        result[COLS_LSB +: DIM_W] = n_dim_q;
      end
      S_MAC: begin
        Addr1  = a_idx;
        Addr2  = b_idx;
        mac_en = 1'b1;
      end
      S_WRITE: begin
        Addr3   = c_idx;
        result  = acc;
        WE      = 1'b1;
        mac_clr = 1'b1;
      end
      default: ;
    endcase
  end

  assign Done      = (state_q == S_DONE);
  assign invalidmm = inv_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      m_dim_q  <= '0;
      k_dim_q  <= '0;
      k2_dim_q <= '0;
      n_dim_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      step_q   <= '0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_dim_q  <= m_dim_d;
      k_dim_q  <= k_dim_d;
      k2_dim_q <= k2_dim_d;
      n_dim_q  <= n_dim_d;
      row_q    <= row_d;
      col_q    <= col_d;
      step_q   <= step_d;
      inv_q    <= inv_d;
    end
  end

  matmul_mac u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (data1),
    .b     (data2),
    .acc_o (acc)
  );

endmodule

// File: tb/tb_matmul_fsm.sv
// Self-checking bench for matmul_fsm: behavioural matrix model, word memories,
// directed cases plus randomized dimensions/values. Honours MATMUL_SAT_EN.
module tb_matmul_fsm;
  import matmul_pkg::*;

  localparam int W      = 32;
  localparam int BUDGET = 3000;
  localparam logic [W-1:0] SENT = 32'hDEAD_BEEF;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [W-1:0]  data1, data2, result;
  logic [6:0]    Addr1, Addr2, Addr3;
  logic          WE, Done, invalidmm;
  state_e        dbg_state;

  logic [W-1:0] mem_a [128];
  logic [W-1:0] mem_b [128];
  logic [W-1:0] mem_c [128];

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt   = 0;
  bit clr_c    = 1'b0;

  matmul_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data1     (data1),
    .data2     (data2),
    .Addr1     (Addr1),
    .Addr2     (Addr2),
    .Addr3     (Addr3),
    .result    (result),
    .WE        (WE),
    .Done      (Done),
    .invalidmm (invalidmm),
    .dbg_state (dbg_state)
  );

  assign data1 = mem_a[Addr1];
  assign data2 = mem_b[Addr2];

  always @(posedge clk) begin
    if (clr_c) begin
      for (int a = 0; a < 128; a++) mem_c[a] <= SENT;
    end else if (WE) begin
      mem_c[Addr3] <= result;
      we_cnt <= we_cnt + 1;
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           exp_lat;
  bit           exp_inv;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: matrix product straight from the header and row-major layout.
  task automatic model_run();
    int m, k, k2, n;
    longint s;
    logic [63:0] sv;
    m  = int'(mem_a[0][7:0]);
    k  = int'(mem_a[0][15:8]);
    k2 = int'(mem_b[0][7:0]);
    n  = int'(mem_b[0][15:8]);
    exp_q.delete();
    exp_inv = (k != k2) || (m == 0) || (k == 0) || (k2 == 0) || (n == 0) ||
              (m * n > 127) || (m * k > 127) || (k2 * n > 127);
    if (exp_inv) begin
      exp_lat = 4;
    end else begin
      exp_lat = 4 + m * n * (k + 1);
      exp_q.push_back({16'h0, n[7:0], m[7:0]});
      for (int r = 0; r < m; r++) begin
        for (int c = 0; c < n; c++) begin
          s = 0;
          for (int t = 0; t < k; t++)
            s += longint'($signed(mem_a[1 + r * k + t])) * longint'($signed(mem_b[1 + t * n + c]));
`ifdef MATMUL_SAT_EN
          if (s > 64'sd2147483647) s = 64'sd2147483647;
          if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
          sv = 64'(s);
          exp_q.push_back(sv[31:0]);
        end
      end
    end
  endtask

  // driver tasks
  task automatic load_hdr(input int m, input int k, input int k2, input int n, input bit wide);
    mem_a[0] = {16'h0, k[7:0], m[7:0]};
    mem_b[0] = {16'h0, n[7:0], k2[7:0]};
    for (int a = 1; a < 128; a++) begin
      mem_a[a] = wide ? $urandom() : $urandom_range(0, 400) - 200;
      mem_b[a] = wide ? $urandom() : $urandom_range(0, 400) - 200;
    end
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic run_case(input string tag, input int hold, input bit chk_clear);
    int edges, done_edge, base;
    model_run();
    clr_c = 1'b1;
    step_edge();
    clr_c = 1'b0;
    step_edge();
    base      = we_cnt;
    start     = 1'b1;
    edges     = 0;
    done_edge = -1;
    while (done_edge < 0 && edges < BUDGET) begin
      step_edge();
      edges++;
      if (edges == hold) start = 1'b0;
      if (chk_clear && edges == 1) check_eq({tag, "/inv_clear"}, W'(invalidmm), '0);
      if (Done) done_edge = edges;
    end
    check_eq({tag, "/done_edge"}, W'(done_edge), W'(exp_lat));
    check_eq({tag, "/invalidmm"}, W'(invalidmm), W'(exp_inv));
    if (hold > edges) begin
      while (edges < hold) begin
        step_edge();
        edges++;
      end
      check_eq({tag, "/held_done"}, W'(Done), W'(1));
      start = 1'b0;
    end
    step_edge();
    check_eq({tag, "/done_release"}, W'(Done), '0);
    step_edge();
    check_eq({tag, "/we_count"}, W'(we_cnt - base), W'(exp_q.size()));
    if (exp_inv) begin
      check_eq({tag, "/no_hdr"}, mem_c[0], SENT);
    end else begin
      for (int idx = 0; exp_q.size() > 0; idx++)
        check_eq($sformatf("%s/c[%0d]", tag, idx), mem_c[idx], exp_q.pop_front());
    end
  endtask

  task automatic load_2x2();
    load_hdr(2, 2, 2, 2, 1'b0);
    mem_a[1] = 1; mem_a[2] = 2; mem_a[3] = 3; mem_a[4] = 4;
    mem_b[1] = 5; mem_b[2] = 6; mem_b[3] = 7; mem_b[4] = 8;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "/Done"}, W'(Done), '0);
    check_eq({tag, "/WE"}, W'(WE), '0);
    check_eq({tag, "/Addr1"}, W'(Addr1), '0);
    check_eq({tag, "/Addr2"}, W'(Addr2), '0);
    check_eq({tag, "/Addr3"}, W'(Addr3), '0);
    check_eq({tag, "/result"}, result, '0);
    check_eq({tag, "/invalidmm"}, W'(invalidmm), '0);
  endtask

  initial begin
    int base, m, k, n;
    rst = 1'b0;
    for (int a = 0; a < 128; a++) begin
      mem_a[a] = '0;
      mem_b[a] = '0;
    end
    repeat (2) step_edge();
    check_reset_outputs("reset");
    rst = 1'b1;
    step_edge();

    // basic 2x2: header 0x0202, 19 22 43 50, Done at edge 16
    load_2x2();
    check_eq("basic/hand_c1", 32'd19, 32'(1 * 5 + 2 * 7));
    run_case("basic", 1, 1'b0);

    // K mismatch with start held through DONE
    load_hdr(2, 3, 2, 2, 1'b0);
    run_case("mismatch_held", 8, 1'b0);

    // start held 5 cycles; invalidmm from previous run must clear in RDHDR
    load_2x2();
    run_case("hold5", 5, 1'b1);

    // non-square 1x3 * 3x1 = 32
    load_hdr(1, 3, 3, 1, 1'b0);
    mem_a[1] = 1; mem_a[2] = 2; mem_a[3] = 3;
    mem_b[1] = 4; mem_b[2] = 5; mem_b[3] = 6;
    run_case("nonsquare", 1, 1'b0);

    // wrap / saturation boundary
    load_hdr(1, 2, 2, 1, 1'b0);
    mem_a[1] = 32'h7FFF_FFFF; mem_a[2] = 32'h1;
    mem_b[1] = 32'h1;         mem_b[2] = 32'h1;
    run_case("wrap_sat", 1, 1'b0);

    // zero dimension and oversize operand
    load_hdr(0, 3, 3, 2, 1'b0);
    run_case("zero_dim", 1, 1'b0);
    load_hdr(12, 12, 12, 1, 1'b0);
    run_case("oversize", 1, 1'b0);

    // randomized dimensions and values
    for (int t = 0; t < 10; t++) begin
      m = $urandom_range(1, 5);
      k = $urandom_range(1, 5);
      n = $urandom_range(1, 5);
      load_hdr(m, k, (t % 4 == 3) ? k + 1 : k, n, t[0]);
      run_case($sformatf("rand%0d", t), $urandom_range(1, 3), 1'b0);
    end

    // reset during MAC of element 2, then rerun
    load_2x2();
    clr_c = 1'b1;
    step_edge();
    clr_c = 1'b0;
    start = 1'b1;
    step_edge();
    start = 1'b0;
    repeat (6) step_edge();
    rst = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    base = we_cnt;
    repeat (3) step_edge();
    check_eq("midrun_reset/no_writes", W'(we_cnt - base), '0);
    check_eq("midrun_reset/c2_untouched", mem_c[2], SENT);
    rst = 1'b1;
    step_edge();
    run_case("after_reset", 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
